// File: rtl/toi2s_pkg.sv
// toi2s_pkg: shared sample/pair types and slot defaults for the S/PDIF-to-I2S path.
package toi2s_pkg;
  typedef logic signed [23:0] i2s_sample_t;
  typedef struct packed {
    i2s_sample_t left;
    i2s_sample_t right;
  } i2s_pair_t;
  localparam int I2S_SLOT_W_DEFAULT = 32;
  localparam int I2S_SAMPLE_W_DEFAULT = 24;
endpackage

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: sync FIFO of L/R sample pairs with synchronous flush and occupancy level.
module i2s_tx_fifo
  import toi2s_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     flush,
  input  logic                     push,
  input  i2s_pair_t                din,
  input  logic                     pop,
  output i2s_pair_t                dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  i2s_pair_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  // a simultaneous pop frees the slot the push needs, so a full push is legal then
  assign do_push = push & (~full | pop);
  assign do_pop = pop & ~empty;
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
  always_ff @(posedge clk) begin
    if (!resetb || flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S stereo transmitter; I2S_TX_UNDERRUN_HOLD_EN repeats the last pair on underrun.
module i2s_tx
  import toi2s_pkg::*;
#(
  parameter int SAMPLE_W   = I2S_SAMPLE_W_DEFAULT,
  parameter int SLOT_W     = I2S_SLOT_W_DEFAULT,
  parameter int BCLK_DIV   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic                          enable,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [SAMPLE_W-1:0]           s_left,
  input  logic [SAMPLE_W-1:0]           s_right,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun
);
  localparam int FW = 2 * SLOT_W;
  localparam int DW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(FW);
  localparam int PAD = SLOT_W - SAMPLE_W;
  if (SLOT_W < SAMPLE_W) $error("SLOT_W must be >= SAMPLE_W");
  if (BCLK_DIV < 2 || BCLK_DIV % 2 != 0) $error("BCLK_DIV must be even and >= 2");
  if ((1 << $clog2(FIFO_DEPTH)) != FIFO_DEPTH) $error("FIFO_DEPTH must be a power of 2");
  logic run, fall, frame_start, first, full, empty, pop;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt, nxt_bit;
  logic [FW-1:0] shreg, load;
  i2s_pair_t in_pair, head, fill, src;
  function automatic logic [SLOT_W-1:0] slot(i2s_sample_t s);
    return SLOT_W'($unsigned(s)) << PAD;
  endfunction
  assign run = resetb & enable;
  assign s_ready = run & ~full;
  assign in_pair = '{left: i2s_sample_t'(s_left), right: i2s_sample_t'(s_right)};
  assign i2s_bclk = div_cnt >= DW'(BCLK_DIV / 2);
  assign fall = div_cnt == DW'(BCLK_DIV - 1);
  // the first fall after enable is forced to be a frame start
  assign nxt_bit = (first || bit_cnt == BW'(FW - 1)) ? '0 : bit_cnt + 1'b1;
  assign frame_start = fall & (nxt_bit == '0);
  assign pop = frame_start & ~empty;
  assign src = empty ? fill : head;
  assign load = {slot(src.left), slot(src.right)};
  i2s_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .resetb(resetb),
    .flush (~enable),
    .push  (s_valid & s_ready),
    .din   (in_pair),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );
`ifdef I2S_TX_UNDERRUN_HOLD_EN
  i2s_pair_t last;
  always_ff @(posedge clk) begin
    if (!run) last <= '0;
    else if (pop) last <= head;
  end
  assign fill = last;
`else
  assign fill = '0;
`endif
  // sd takes the register MSB on every fall, so the bit loaded at frame start lands one BCLK later
  always_ff @(posedge clk) begin
    if (!run) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      first <= 1'b1;
      i2s_lrclk <= 1'b0;
      i2s_sd <= 1'b0;
      underrun <= 1'b0;
      shreg <= '0;
    end else begin
      div_cnt <= fall ? '0 : div_cnt + 1'b1;
      underrun <= frame_start & empty;
      if (fall) begin
        bit_cnt <= nxt_bit;
        first <= 1'b0;
        i2s_lrclk <= nxt_bit >= BW'(SLOT_W);
        i2s_sd <= shreg[FW-1];
        shreg <= frame_start ? load : shreg << 1;
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: scoreboard bench for i2s_tx with an independent cycle-count timing model.
module tb_i2s_tx;
  logic clk = 1'b0, resetb, enable, s_valid, s_ready;
  logic [23:0] s_left, s_right;
  logic i2s_bclk, i2s_lrclk, i2s_sd, underrun;
  logic [2:0] fifo_level;
  int errors = 0, checks = 0, ecnt = 0;
  logic [47:0] sb[$];
  logic [47:0] cur = '0, last = '0;

  i2s_tx dut (
    .clk(clk), .resetb(resetb), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk),
    .i2s_sd(i2s_sd), .fifo_level(fifo_level), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic sd_model(int b, logic [47:0] p);
    int pos, idx;
    logic [23:0] s;
    if (b == 0) return 1'b0;
    pos = b - 1;
    idx = pos % 32;
    s = (pos >= 32) ? p[23:0] : p[47:24];
    return (idx < 24) ? s[23 - idx] : 1'b0;
  endfunction

  always @(posedge clk) begin
    logic en_ok, acc, fs, exp_ur;
    int b;
    #1;
    en_ok = resetb && enable;
    acc = en_ok && s_valid && sb.size() < 4;
    if (!en_ok) begin
      ecnt = 0;
      sb.delete();
      last = '0;
      cur = '0;
    end else ecnt++;
    fs = en_ok && ecnt >= 8 && (ecnt - 8) % 512 == 0;
    exp_ur = fs && sb.size() == 0;
    if (fs) begin
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        last = cur;
      end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        cur = last;
`else
        cur = '0;
`endif
      end
    end
    if (acc) sb.push_back({s_left, s_right});
    b = (ecnt < 8) ? 0 : ((ecnt - 8) / 8) % 64;
    check("bclk", 32'(i2s_bclk), 32'((ecnt % 8) >= 4));
    check("lrclk", 32'(i2s_lrclk), 32'(b >= 32));
    check("underrun", 32'(underrun), 32'(exp_ur));
    check("level", 32'(fifo_level), 32'(sb.size()));
    check("s_ready", 32'(s_ready), 32'(en_ok && sb.size() < 4));
    if (ecnt % 8 == 4 || !en_ok) check("sd", 32'(i2s_sd), 32'(sd_model(b, cur)));
  end

  task automatic send(logic [23:0] l, logic [23:0] r);
    int t = 0;
    s_left = l;
    s_right = r;
    s_valid = 1'b1;
    while (!s_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("send_timeout", 32'(t), 32'(0));
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_until_bit10;
    int t = 0;
    while (!(ecnt >= 8 && ((ecnt - 8) / 8) % 64 == 10) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("bit10_timeout", 32'(t), 32'(0));
  endtask

  initial begin
    int t;
    resetb = 1'b0;
    enable = 1'b1;
    s_valid = 1'b0;
    s_left = '0;
    s_right = '0;
    repeat (5) @(negedge clk);
    check("rst_level", 32'(fifo_level), 32'(0));
    check("rst_ready", 32'(s_ready), 32'(0));
    resetb = 1'b1;
    send(24'hA5A5A5, 24'h5A5A5A);
    repeat (1100) @(negedge clk);
    enable = 1'b0;
    fork
      for (int i = 0; i < 5; i++) send(24'($urandom), 24'($urandom));
      begin
        repeat (20) @(negedge clk);
        enable = 1'b1;
      end
    join
    t = 0;
    while (!((ecnt + 1 - 8) % 512 == 0 && ecnt + 1 >= 8 && sb.size() < 4) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) check("align_timeout", 32'(t), 32'(0));
    send(24'h123456, 24'hFEDCBA);
    t = 0;
    while (sb.size() != 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4000) check("drain_timeout", 32'(t), 32'(0));
    repeat (600) @(negedge clk);
    send(24'h800001, 24'h7FFFFE);
    send(24'h0F0F0F, 24'hF0F0F0);
    wait_until_bit10();
    enable = 1'b0;
    @(negedge clk);
    check("abort_level", 32'(fifo_level), 32'(0));
    check("abort_bclk", 32'(i2s_bclk), 32'(0));
    repeat (5) @(negedge clk);
    enable = 1'b1;
    send(24'hC3C3C3, 24'h3C3C3C);
    repeat (1100) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
